image_rom_arbiter: RTL and testbench

// Round-robin arbiter sharing one single-port, registered-read image ROM (12-bit address {y[5:0],x[5:0]},
// 12-bit RGB444 data) between N_REQ pixel fetchers (e.g. board, ship and cursor draw units).

---
 rtl/image_rom_arbiter.sv | 79 +++++++
 tb/tb_image_rom_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/image_rom_arbiter.sv
// Round-robin arbiter sharing one registered-read image ROM between N_REQ pixel fetchers.
// Each accepted read returns one rd_valid pulse, tagged with the requester id, ROM_LAT cycles after its grant.
module image_rom_arbiter #(
   parameter int N_REQ   = 2,
   parameter int ROM_LAT = 1,
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*ADDR_W-1:0]  req_addr,
   output logic [N_REQ-1:0]         gnt,
   output logic [N_REQ-1:0]         rd_valid,
   output logic [DATA_W-1:0]        rd_data,
   output logic [ADDR_W-1:0]        rom_address,
   input  logic [DATA_W-1:0]        rom_rgb
);

   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [ID_W-1:0]    last_gnt;
   logic [ID_W-1:0]    gnt_id;
   logic               gnt_any;
   logic [ROM_LAT-1:0] pipe_v;
   logic [ID_W-1:0]    pipe_id [ROM_LAT];

   // Handshake: a requester holds req[i] and its address until it sees gnt[i] in the
   // same cycle; the read is taken on that rising edge and req may change afterwards.
   always_comb begin
      int idx;
      gnt     = '0;
      gnt_id  = '0;
      gnt_any = 1'b0;
      idx     = 0;
      if (rst_n) begin
         for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_gnt) + k) % N_REQ;
            if (!gnt_any && req[idx]) begin
               gnt_any     = 1'b1;
               gnt_id      = ID_W'(idx);
               gnt[idx]    = 1'b1;
            end
         end
      end
   end

   always_comb begin
      rom_address = '0;
      if (gnt_any)
         rom_address = req_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
   end

   // Return pipeline mirrors the ROM latency so each datum is tagged with its requester.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pipe_v   <= '0;
         last_gnt <= ID_W'(N_REQ - 1);
      end else begin
         pipe_v[0]  <= gnt_any;
         pipe_id[0] <= gnt_id;
         for (int i = 1; i < ROM_LAT; i++) begin
            pipe_v[i]  <= pipe_v[i-1];
            pipe_id[i] <= pipe_id[i-1];
         end
         if (gnt_any)
            last_gnt <= gnt_id;
      end
   end

   always_comb begin
      rd_valid = '0;
      if (pipe_v[ROM_LAT-1])
         rd_valid[pipe_id[ROM_LAT-1]] = 1'b1;
   end

   assign rd_data = rom_rgb;

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Directed bench for image_rom_arbiter: a 2-requester/latency-1 instance and a
// 3-requester/latency-2 instance, each fed by a small registered ROM model.
module tb_image_rom_arbiter;

   typedef struct {
      logic        rst_n;
      logic [2:0]  req;
      logic [11:0] a0, a1, a2;
      logic [2:0]  gnt;
      logic [11:0] addr;
      logic [2:0]  vld;
      logic        chk;
      logic [11:0] data;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Instance A: N_REQ=2, ROM_LAT=1
   logic        rst_n_a = 1'b0;
   logic [1:0]  req_a = '0;
   logic [23:0] addr_a = '0;
   logic [1:0]  gnt_a, vld_a;
   logic [11:0] data_a, rom_addr_a, rom_rgb_a;

   // Instance B: N_REQ=3, ROM_LAT=2
   logic        rst_n_b = 1'b0;
   logic [2:0]  req_b = '0;
   logic [35:0] addr_b = '0;
   logic [2:0]  gnt_b, vld_b;
   logic [11:0] data_b, rom_addr_b, rom_rgb_b, rom_b1;

   image_rom_arbiter #(.N_REQ(2), .ROM_LAT(1), .ADDR_W(12), .DATA_W(12)) dut_a (
      .clk(clk), .rst_n(rst_n_a), .req(req_a), .req_addr(addr_a), .gnt(gnt_a),
      .rd_valid(vld_a), .rd_data(data_a), .rom_address(rom_addr_a), .rom_rgb(rom_rgb_a));

   image_rom_arbiter #(.N_REQ(3), .ROM_LAT(2), .ADDR_W(12), .DATA_W(12)) dut_b (
      .clk(clk), .rst_n(rst_n_b), .req(req_b), .req_addr(addr_b), .gnt(gnt_b),
      .rd_valid(vld_b), .rd_data(data_b), .rom_address(rom_addr_b), .rom_rgb(rom_rgb_b));

   function automatic logic [11:0] rom_fn(input logic [11:0] a);
      return {a[3:0], a[11:4]} ^ 12'h5C3;
   endfunction

   always @(posedge clk) begin
      rom_rgb_a <= rom_fn(rom_addr_a);
      rom_b1    <= rom_fn(rom_addr_b);
      rom_rgb_b <= rom_b1;
   end

   function automatic vec_t mk(input logic r, input logic [2:0] rq, input logic [11:0] x0,
                               input logic [11:0] x1, input logic [11:0] x2, input logic [2:0] g,
                               input logic [11:0] ad, input logic [2:0] v, input logic [11:0] da);
      vec_t t;
      t.rst_n = r;  t.req = rq; t.a0 = x0; t.a1 = x1; t.a2 = x2;
      t.gnt = g;    t.addr = ad; t.vld = v; t.chk = (v != 3'b000); t.data = rom_fn(da);
      return t;
   endfunction

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input bit use_b, input int row);
      @(negedge clk);
      if (!use_b) begin
         rst_n_a = v.rst_n; req_a = v.req[1:0]; addr_a = {v.a1, v.a0};
      end else begin
         rst_n_b = v.rst_n; req_b = v.req; addr_b = {v.a2, v.a1, v.a0};
      end
      #1;
      n_vec++;
      if (!use_b) begin
         chk($sformatf("A row%0d gnt", row), 12'({1'b0, gnt_a}), 12'(v.gnt));
         chk($sformatf("A row%0d rom_address", row), rom_addr_a, v.addr);
         chk($sformatf("A row%0d rd_valid", row), 12'({1'b0, vld_a}), 12'(v.vld));
         if (v.chk) chk($sformatf("A row%0d rd_data", row), data_a, v.data);
      end else begin
         chk($sformatf("B row%0d gnt", row), 12'(gnt_b), 12'(v.gnt));
         chk($sformatf("B row%0d rom_address", row), rom_addr_b, v.addr);
         chk($sformatf("B row%0d rd_valid", row), 12'(vld_b), 12'(v.vld));
         if (v.chk) chk($sformatf("B row%0d rd_data", row), data_b, v.data);
      end
   endtask

   vec_t va[$];
   vec_t vb[$];
   logic [2:0]  hold;
   int          wait_c[3];
   logic [11:0] fa[3];

   initial begin
      // Instance A table
      va.push_back(mk(0, 3'b011, 12'h123, 12'h456, 0, 3'b000, 12'h000, 3'b000, 0));
      va.push_back(mk(1, 3'b001, 12'h041, 12'h000, 0, 3'b001, 12'h041, 3'b000, 0));
      va.push_back(mk(1, 3'b000, 12'h041, 12'h000, 0, 3'b000, 12'h000, 3'b001, 12'h041));
      va.push_back(mk(0, 3'b000, 12'h000, 12'h000, 0, 3'b000, 12'h000, 3'b000, 0));
      va.push_back(mk(1, 3'b011, 12'h100, 12'h200, 0, 3'b001, 12'h100, 3'b000, 0));
      va.push_back(mk(1, 3'b011, 12'h101, 12'h201, 0, 3'b010, 12'h201, 3'b001, 12'h100));
      va.push_back(mk(1, 3'b011, 12'h102, 12'h202, 0, 3'b001, 12'h102, 3'b010, 12'h201));
      va.push_back(mk(1, 3'b011, 12'h103, 12'h203, 0, 3'b010, 12'h203, 3'b001, 12'h102));
      va.push_back(mk(1, 3'b000, 12'h000, 12'h000, 0, 3'b000, 12'h000, 3'b010, 12'h203));
      for (int k = 0; k < 8; k++)
         va.push_back(mk(1, 3'b010, 12'hFFF, 12'(k), 0, 3'b010, 12'(k),
                         (k == 0) ? 3'b000 : 3'b010, 12'(k - 1)));
      va.push_back(mk(1, 3'b000, 12'h000, 12'h000, 0, 3'b000, 12'h000, 3'b010, 12'h007));
      for (int k = 0; k < 10; k++)
         va.push_back(mk(1, 3'b000, 12'hABC, 12'hDEF, 0, 3'b000, 12'h000, 3'b000, 0));
      va.push_back(mk(1, 3'b011, 12'h0AA, 12'h0BB, 0, 3'b001, 12'h0AA, 3'b000, 0));
      va.push_back(mk(1, 3'b010, 12'h0AA, 12'h0BC, 0, 3'b010, 12'h0BC, 3'b001, 12'h0AA));
      va.push_back(mk(1, 3'b000, 12'h000, 12'h000, 0, 3'b000, 12'h000, 3'b010, 12'h0BC));

      // Instance B table: late req[2] against held req[0], then reset with reads in flight
      vb.push_back(mk(0, 3'b000, 12'h000, 12'h000, 12'h000, 3'b000, 12'h000, 3'b000, 0));
      vb.push_back(mk(1, 3'b001, 12'h010, 12'h000, 12'h000, 3'b001, 12'h010, 3'b000, 0));
      vb.push_back(mk(1, 3'b001, 12'h011, 12'h000, 12'h000, 3'b001, 12'h011, 3'b000, 0));
      vb.push_back(mk(1, 3'b101, 12'h012, 12'h000, 12'h020, 3'b100, 12'h020, 3'b001, 12'h010));
      vb.push_back(mk(1, 3'b101, 12'h012, 12'h000, 12'h021, 3'b001, 12'h012, 3'b001, 12'h011));
      vb.push_back(mk(1, 3'b101, 12'h013, 12'h000, 12'h021, 3'b100, 12'h021, 3'b100, 12'h020));
      vb.push_back(mk(1, 3'b001, 12'h014, 12'h000, 12'h000, 3'b001, 12'h014, 3'b001, 12'h012));
      vb.push_back(mk(1, 3'b111, 12'h015, 12'h030, 12'h040, 3'b010, 12'h030, 3'b100, 12'h021));
      vb.push_back(mk(1, 3'b111, 12'h015, 12'h031, 12'h040, 3'b100, 12'h040, 3'b001, 12'h014));
      vb.push_back(mk(1, 3'b111, 12'h015, 12'h031, 12'h041, 3'b001, 12'h015, 3'b010, 12'h030));
      vb.push_back(mk(1, 3'b111, 12'h016, 12'h031, 12'h041, 3'b010, 12'h031, 3'b100, 12'h040));
      vb.push_back(mk(0, 3'b111, 12'h016, 12'h032, 12'h041, 3'b000, 12'h000, 3'b001, 12'h015));
      vb.push_back(mk(1, 3'b111, 12'h050, 12'h051, 12'h052, 3'b001, 12'h050, 3'b000, 0));
      vb.push_back(mk(1, 3'b000, 12'h000, 12'h000, 12'h000, 3'b000, 12'h000, 3'b000, 0));
      vb.push_back(mk(1, 3'b000, 12'h000, 12'h000, 12'h000, 3'b000, 12'h000, 3'b001, 12'h050));
      vb.push_back(mk(1, 3'b000, 12'h000, 12'h000, 12'h000, 3'b000, 12'h000, 3'b000, 0));

      repeat (2) @(negedge clk);
      foreach (va[i]) apply(va[i], 1'b0, i);
      foreach (vb[i]) apply(vb[i], 1'b1, i);

      // Random held requests on B: every waiting requester must be served within 3 cycles
      hold = '0;
      for (int i = 0; i < 3; i++) begin wait_c[i] = 0; fa[i] = '0; end
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++)
            if (!hold[i] && $urandom_range(0, 1) == 1) begin
               hold[i] = 1'b1;
               fa[i]   = 12'($urandom_range(0, 4095));
            end
         req_b = hold; addr_b = {fa[2], fa[1], fa[0]};
         #1;
         n_vec++;
         chk($sformatf("fair c%0d gnt_count", c), 12'($countones(gnt_b)), (hold != 3'b000) ? 12'd1 : 12'd0);
         chk($sformatf("fair c%0d gnt_subset", c), 12'(gnt_b & ~hold), 12'h000);
         for (int i = 0; i < 3; i++) begin
            if (hold[i] && gnt_b[i]) begin
               chk($sformatf("fair c%0d rom_address", c), rom_addr_b, fa[i]);
               hold[i] = 1'b0; wait_c[i] = 0;
            end else if (hold[i]) begin
               wait_c[i]++;
               if (wait_c[i] > 2) begin
                  n_err++;
                  $display("FAIL fair c%0d starve req%0d: waited %0d cycles, limit 2", c, i, wait_c[i]);
               end
            end
         end
      end
      @(negedge clk);
      req_b = '0;
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
